// File: rtl/uart_rx_ctrl.sv
// UART receive controller: syncs the divider's oversample clock into a tick,
// frames start/data/stop on rx and hands bytes out on a valid/ready port.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 os_clk,
    input  logic                 rx,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] MID_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] END_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_q1, rx_s;
    logic                 os_q1, os_q2, os_q3;
    logic                 tick;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // Line idles high, so the rx synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
            os_q1 <= 1'b0;
            os_q2 <= 1'b0;
            os_q3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
            os_q1 <= os_clk;
            os_q2 <= os_q1;
            os_q3 <= os_q2;
            tick  <= os_q2 & ~os_q3;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (!rx_en) begin
                state   <= IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == MID_CNT) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == END_CNT) begin
                            cnt   <= '0;
                            shreg <= DATA_BITS'({rx_s, shreg} >> 1);
                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
                                state   <= STOP;
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == END_CNT) begin
                            cnt   <= '0;
                            state <= IDLE;
                            // A later write here overrides the ready-driven clear.
                            if (rx_s) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                                overrun  <= rx_valid && !rx_ready;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames driven on rx at 115200 baud,
// expected bytes queued and popped as the consumer accepts them.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int BIT_NS = 8640;
    localparam int OS_NS  = 540;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       os_clk = 1'b0;
    logic       rx = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .os_clk(os_clk),
        .rx(rx),
        .rx_en(rx_en),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #10 clk = ~clk;
    always #(OS_NS / 2) os_clk = ~os_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: pop the scoreboard on each accepted byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0)
                    check("spurious_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
                else
                    check("rx_data", {24'd0, rx_data},
                          {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = stop;
        #(BIT_NS);
        rx = 1'b1;
        #(BIT_NS);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        rx_ready = v;
    endtask

    initial begin
        #95;
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_data", {24'd0, rx_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        check("rst_ovr", {31'd0, overrun}, 0);
        rst_n = 1'b1;
        #(BIT_NS);

        // 1: single byte, consumer always ready
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        check("t1_empty", exp_q.size(), 0);
        check("t1_valid", {31'd0, rx_valid}, 0);
        check("t1_ferr", fe_cnt, 0);
        check("t1_ovr", ov_cnt, 0);

        // 2: back-to-back bytes with consumer stalled
        set_ready(1'b0);
        send(8'h00, 1'b1);
        check("t2_valid1", {31'd0, rx_valid}, 1);
        check("t2_data1", {24'd0, rx_data}, 32'h00);
        check("t2_ovr0", ov_cnt, 0);
        exp_q.push_back(8'hFF);
        send(8'hFF, 1'b1);
        check("t2_ovr1", ov_cnt, 1);
        check("t2_valid2", {31'd0, rx_valid}, 1);
        check("t2_data2", {24'd0, rx_data}, 32'hFF);
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        check("t2_empty", exp_q.size(), 0);
        check("t2_vfall", {31'd0, rx_valid}, 0);

        // 3: bad stop bit, then a good byte
        send(8'h3C, 1'b0);
        check("t3_ferr", fe_cnt, 1);
        check("t3_empty", exp_q.size(), 0);
        #(BIT_NS);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        check("t3_empty2", exp_q.size(), 0);
        check("t3_ferr2", fe_cnt, 1);
        check("t3_ovr", ov_cnt, 1);

        // 4: short low glitch on the line
        rx = 1'b0;
        #(3 * OS_NS);
        check("t4_busy", {31'd0, busy}, 1);
        rx = 1'b1;
        #(BIT_NS);
        check("t4_idle", {31'd0, busy}, 0);
        check("t4_valid", {31'd0, rx_valid}, 0);
        check("t4_ferr", fe_cnt, 1);
        check("t4_ovr", ov_cnt, 1);

        // 5: reset in the middle of a frame while a byte is pending
        set_ready(1'b0);
        exp_q.push_back(8'h42);
        send(8'h42, 1'b1);
        check("t5_pend", {24'd0, rx_data}, 32'h42);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h81 >> i);
            #(BIT_NS);
        end
        rx = 1'b0;
        #(BIT_NS / 2);
        check("t5_busy_pre", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("t5_valid", {31'd0, rx_valid}, 0);
        check("t5_data", {24'd0, rx_data}, 0);
        check("t5_busy", {31'd0, busy}, 0);
        exp_q.delete();
        rx = 1'b1;
        #(2 * BIT_NS);
        rst_n = 1'b1;
        set_ready(1'b1);
        #(BIT_NS);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1);
        check("t5_empty", exp_q.size(), 0);

        // 6: receiver disabled mid-frame
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h33 >> i);
            #(BIT_NS);
        end
        rx_en = 1'b0;
        #100;
        check("t6_busy", {31'd0, busy}, 0);
        for (int i = 3; i < 8; i++) begin
            rx = 1'(8'h33 >> i);
            #(BIT_NS);
        end
        rx = 1'b1;
        #(2 * BIT_NS);
        rx_en = 1'b1;
        #(BIT_NS);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1);
        check("t6_empty", exp_q.size(), 0);
        check("t6_ferr", fe_cnt, 1);
        check("t6_ovr", ov_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
